// File: rtl/cp0_timer_if.sv
// rtl/cp0_timer_if.sv - CP0 timer software, exception and interrupt bus
// master drives reads, writes, exception/ERET commits and interrupt lines; slave is the CP0 block.
interface cp0_timer_if #(
    parameter int HW_INTR_N = 6
);
    logic [4:0]           rd_addr;
    logic [31:0]          rd_data;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic [31:0]          wr_data;
    logic                 exc_we;
    logic                 exc_bd;
    logic [4:0]           exc_code;
    logic [31:0]          exc_epc;
    logic [31:0]          exc_bva;
    logic                 eret;
    logic [HW_INTR_N-1:0] hard_intr;
    logic [7:0]           intr_vect;
    logic [31:0]          er_epc;
    logic                 timer_intr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output exc_we, exc_bd, exc_code, exc_epc, exc_bva, eret, hard_intr,
        input  rd_data, intr_vect, er_epc, timer_intr
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  exc_we, exc_bd, exc_code, exc_epc, exc_bva, eret, hard_intr,
        output rd_data, intr_vect, er_epc, timer_intr
    );
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 BadVAddr/Status/Cause/EPC with optional Count/Compare timer
// Define CP0_TIMER_EN to build Count (reg 9), Compare (reg 11) and the timer interrupt.
module cp0_timer #(
    parameter int HW_INTR_N = 6,
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    cp0_timer_if.slave  bus
);
    logic [31:0]          badvaddr_q, badvaddr_d;
    logic [31:0]          epc_q, epc_d;
    logic [7:0]           im_q, im_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic                 bd_q, bd_d;
    logic [4:0]           exccode_q, exccode_d;
    logic [1:0]           ip_sw_q, ip_sw_d;
    logic [HW_INTR_N-1:0] ip_hw_q;

    logic        sw_we;
    logic        ti_cur;
    logic [31:0] count_rd, compare_rd;
    logic [5:0]  hw_ip;
    logic [31:0] status_rd, cause_rd;

    // Lower-priority events in the same cycle are dropped, so a software write only counts when alone.
    assign sw_we = bus.wr_en & ~bus.exc_we & ~bus.eret;

    always_comb begin
        badvaddr_d = badvaddr_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        if (bus.exc_we) begin
            bd_d       = bus.exc_bd;
            exccode_d  = bus.exc_code;
            exl_d      = 1'b1;
            epc_d      = bus.exc_epc;
            badvaddr_d = bus.exc_bva;
        end else if (bus.eret) begin
            exl_d = 1'b0;
        end else if (bus.wr_en) begin
            case (bus.wr_addr)
                5'd12: begin
                    im_d  = bus.wr_data[15:8];
                    exl_d = bus.wr_data[1];
                    ie_d  = bus.wr_data[0];
                end
                5'd13:   ip_sw_d = bus.wr_data[9:8];
                5'd14:   epc_d   = bus.wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= bus.hard_intr;
        end
    end

`ifdef CP0_TIMER_EN
    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

    logic [3:0]  div_q, div_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        count_wr, cmp_wr, div_wrap;

    assign count_wr = sw_we && (bus.wr_addr == 5'd9);
    assign cmp_wr   = sw_we && (bus.wr_addr == 5'd11);
    assign div_wrap = (div_q == DIV_LAST);

    always_comb begin
        div_d     = div_q + 4'd1;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_wr) begin
            div_d   = 4'd0;
            count_d = bus.wr_data;
        end else if (div_wrap) begin
            div_d   = 4'd0;
            count_d = count_q + 32'd1;
        end
        // A Compare write wins over a match landing on the same edge.
        if (cmp_wr) begin
            compare_d = bus.wr_data;
            ti_d      = 1'b0;
        end else if (!count_wr && div_wrap && (count_q + 32'd1 == compare_q)) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_rd   = count_wr ? bus.wr_data : count_q;
    assign compare_rd = cmp_wr ? bus.wr_data : compare_q;
    assign ti_cur     = ti_q;
`else
    assign count_rd   = '0;
    assign compare_rd = '0;
    assign ti_cur     = 1'b0;
`endif

    // hw_ip holds IP7..IP2; IP7 also carries the timer interrupt.
    always_comb begin
        hw_ip = '0;
        for (int i = 0; i < HW_INTR_N; i++) begin
            hw_ip[i] = ip_hw_q[i];
        end
        hw_ip[5] = hw_ip[5] | ti_cur;
    end

    // Read views use the _d values so the winning same-cycle update is visible immediately.
    assign status_rd = {16'd0, im_d, 6'd0, exl_d, ie_d};
    assign cause_rd  = {bd_d, ti_cur, 14'd0, hw_ip, ip_sw_d, 1'b0, exccode_d, 2'b00};

    always_comb begin
        case (bus.rd_addr)
            5'd8:    bus.rd_data = badvaddr_d;
            5'd9:    bus.rd_data = count_rd;
            5'd11:   bus.rd_data = compare_rd;
            5'd12:   bus.rd_data = status_rd;
            5'd13:   bus.rd_data = cause_rd;
            5'd14:   bus.rd_data = epc_d;
            default: bus.rd_data = '0;
        endcase
    end

    assign bus.intr_vect  = (ie_q && !exl_q) ? ({hw_ip, ip_sw_q} & im_q) : 8'h00;
    assign bus.er_epc     = epc_q;
    assign bus.timer_intr = ti_cur;
endmodule
